// File: rtl/bus_alu_datapath.sv
// Single-bus execution datapath: register bank, operand buffer, ALU and C/V/S/Z flags
// driven by an internal IDLE/LOAD_A/EXEC/DONE transfer sequencer.
module bus_alu_datapath #(
  parameter int WIDTH  = 16,
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [2:0]        op_fsel,
  input  logic [REG_AW-1:0] op_src_a,
  input  logic [REG_AW-1:0] op_src_b,
  input  logic              op_imm_en,
  input  logic [WIDTH-1:0]  op_imm,
  input  logic [REG_AW-1:0] op_dst,
  output logic              done,
  output logic [WIDTH-1:0]  result,
  output logic              C,
  output logic              V,
  output logic              S,
  output logic              Z,
  input  logic [REG_AW-1:0] dbg_sel,
  output logic [WIDTH-1:0]  dbg_data
);

  localparam int NREG = 2 ** REG_AW;
  localparam logic [WIDTH:0] ONE_X = {{WIDTH{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, LOAD_A, EXEC, DONE} state_t;

  localparam logic [2:0] F_ADD = 3'b000;
  localparam logic [2:0] F_SUB = 3'b001;
  localparam logic [2:0] F_AND = 3'b010;
  localparam logic [2:0] F_OR  = 3'b011;
  localparam logic [2:0] F_XOR = 3'b100;
  localparam logic [2:0] F_NOT = 3'b101;
  localparam logic [2:0] F_MOV = 3'b110;
  localparam logic [2:0] F_INC = 3'b111;

  state_t state, state_nx;

  logic [2:0]        fsel_q;
  logic [REG_AW-1:0] src_a_q, src_b_q, dst_q;
  logic              imm_en_q;
  logic [WIDTH-1:0]  imm_q;
  logic [WIDTH-1:0]  buff;
  logic [WIDTH-1:0]  regs [NREG];

  logic [WIDTH-1:0]  alu_a, alu_b, alu_r;
  logic [WIDTH:0]    alu_sum;
  logic              alu_c, alu_v;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (op_valid) state_nx = LOAD_A;
      LOAD_A:  state_nx = EXEC;
      EXEC:    state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    op_ready = (state == IDLE);
    done     = (state == DONE);
  end

  // The request is captured once at acceptance so the bus fields may change afterwards.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsel_q   <= '0;
      src_a_q  <= '0;
      src_b_q  <= '0;
      dst_q    <= '0;
      imm_en_q <= 1'b0;
      imm_q    <= '0;
    end else if (state == IDLE && op_valid) begin
      fsel_q   <= op_fsel;
      src_a_q  <= op_src_a;
      src_b_q  <= op_src_b;
      dst_q    <= op_dst;
      imm_en_q <= op_imm_en;
      imm_q    <= op_imm;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                 buff <= '0;
    else if (state == LOAD_A) buff <= regs[src_a_q];
  end

  assign alu_a = buff;
  assign alu_b = imm_en_q ? imm_q : regs[src_b_q];

  // Carry and overflow are only meaningful for the arithmetic functions; all others clear them.
  always_comb begin
    alu_sum = '0;
    alu_r   = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (fsel_q)
      F_ADD: begin
        alu_sum = {1'b0, alu_a} + {1'b0, alu_b};
        alu_r   = alu_sum[WIDTH-1:0];
        alu_c   = alu_sum[WIDTH];
        alu_v   = (alu_a[WIDTH-1] == alu_b[WIDTH-1]) && (alu_r[WIDTH-1] != alu_a[WIDTH-1]);
      end
      F_SUB: begin
        alu_sum = {1'b0, alu_a} + {1'b0, ~alu_b} + ONE_X;
        alu_r   = alu_sum[WIDTH-1:0];
        alu_c   = alu_sum[WIDTH];
        alu_v   = (alu_a[WIDTH-1] != alu_b[WIDTH-1]) && (alu_r[WIDTH-1] != alu_a[WIDTH-1]);
      end
      F_AND: alu_r = alu_a & alu_b;
      F_OR:  alu_r = alu_a | alu_b;
      F_XOR: alu_r = alu_a ^ alu_b;
      F_NOT: alu_r = ~alu_a;
      F_MOV: alu_r = alu_b;
      F_INC: begin
        alu_sum = {1'b0, alu_a} + ONE_X;
        alu_r   = alu_sum[WIDTH-1:0];
        alu_c   = alu_sum[WIDTH];
        alu_v   = !alu_a[WIDTH-1] && alu_r[WIDTH-1];
      end
      default: alu_r = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (state == EXEC) begin
      regs[dst_q] <= alu_r;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result <= '0;
      C      <= 1'b0;
      V      <= 1'b0;
      S      <= 1'b0;
      Z      <= 1'b0;
    end else if (state == EXEC) begin
      result <= alu_r;
      C      <= alu_c;
      V      <= alu_v;
      S      <= alu_r[WIDTH-1];
      Z      <= (alu_r == '0);
    end
  end

  assign dbg_data = regs[dbg_sel];

endmodule

// File: tb/tb_bus_alu_datapath.sv
// Bench for bus_alu_datapath: a 16-bit/8-register and an 8-bit/4-register instance
// checked every cycle against an arithmetic reference model, plus literal expectations.
module tb_bus_alu_datapath;

  logic clk;
  logic rst;

  logic        op_valid  [2];
  logic [2:0]  op_fsel   [2];
  logic [2:0]  op_src_a  [2];
  logic [2:0]  op_src_b  [2];
  logic        op_imm_en [2];
  logic [15:0] op_imm    [2];
  logic [2:0]  op_dst    [2];
  logic [2:0]  dbg_sel   [2];

  logic        w_ready, w_done, w_c, w_v, w_s, w_z;
  logic [15:0] w_result, w_dbg;
  logic        n_ready, n_done, n_c, n_v, n_s, n_z;
  logic [7:0]  n_result, n_dbg;

  logic        rdy_o  [2];
  logic        done_o [2];
  logic [15:0] res_o  [2];
  logic [15:0] dbg_o  [2];
  logic [3:0]  flg_o  [2];

  int n_checks = 0;
  int n_fail   = 0;

  bus_alu_datapath #(.WIDTH(16), .REG_AW(3)) u_wide (
    .clk(clk), .rst(rst),
    .op_valid(op_valid[0]), .op_ready(w_ready), .op_fsel(op_fsel[0]),
    .op_src_a(op_src_a[0]), .op_src_b(op_src_b[0]), .op_imm_en(op_imm_en[0]),
    .op_imm(op_imm[0]), .op_dst(op_dst[0]), .done(w_done), .result(w_result),
    .C(w_c), .V(w_v), .S(w_s), .Z(w_z), .dbg_sel(dbg_sel[0]), .dbg_data(w_dbg)
  );

  bus_alu_datapath #(.WIDTH(8), .REG_AW(2)) u_narrow (
    .clk(clk), .rst(rst),
    .op_valid(op_valid[1]), .op_ready(n_ready), .op_fsel(op_fsel[1]),
    .op_src_a(op_src_a[1][1:0]), .op_src_b(op_src_b[1][1:0]), .op_imm_en(op_imm_en[1]),
    .op_imm(op_imm[1][7:0]), .op_dst(op_dst[1][1:0]), .done(n_done), .result(n_result),
    .C(n_c), .V(n_v), .S(n_s), .Z(n_z), .dbg_sel(dbg_sel[1][1:0]), .dbg_data(n_dbg)
  );

  assign rdy_o[0]  = w_ready;
  assign rdy_o[1]  = n_ready;
  assign done_o[0] = w_done;
  assign done_o[1] = n_done;
  assign res_o[0]  = w_result;
  assign res_o[1]  = {8'h00, n_result};
  assign dbg_o[0]  = w_dbg;
  assign dbg_o[1]  = {8'h00, n_dbg};
  assign flg_o[0]  = {w_c, w_v, w_s, w_z};
  assign flg_o[1]  = {n_c, n_v, n_s, n_z};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input int inst, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s inst=%0d actual=0x%0h expected=0x%0h", name, inst, act, exp);
    end
  endtask

  // Reference ALU in plain integer arithmetic: signed overflow means the true signed result
  // does not fit in w bits, and subtract carry means no borrow.
  function automatic void alu_model(input int w, input logic [2:0] f, input longint a,
                                    input longint b, output longint r, output bit c, output bit v);
    longint m, half, sa, sb, full, ss;
    m    = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    sa   = (a >= half) ? a - (m + 1) : a;
    sb   = (b >= half) ? b - (m + 1) : b;
    full = 0;
    ss   = 0;
    c    = 1'b0;
    v    = 1'b0;
    case (f)
      3'd0: begin full = a + b; ss = sa + sb; c = (full > m); v = (ss >= half) || (ss < -half); end
      3'd1: begin full = a - b; ss = sa - sb; c = (a >= b);   v = (ss >= half) || (ss < -half); end
      3'd2: full = a & b;
      3'd3: full = a | b;
      3'd4: full = a ^ b;
      3'd5: full = ~a;
      3'd6: full = b;
      default: begin full = a + 1; ss = sa + 1; c = (full > m); v = (ss >= half); end
    endcase
    r = full & m;
  endfunction

  longint     m_regs [2][8];
  longint     m_res  [2];
  bit         m_c [2], m_v [2], m_s [2], m_z [2];
  int         m_cnt  [2];
  logic [2:0] q_f    [2];
  int         q_a [2], q_b [2], q_dst [2];
  bit         q_ie   [2];
  longint     q_imm  [2];

  // Model counts cycles since acceptance; the result lands on the third edge and the
  // block is free again one cycle later.
  always @(posedge clk or negedge rst) begin : model
    longint a, b, r, vm;
    bit c, v;
    int w, im;
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        for (int j = 0; j < 8; j++) m_regs[i][j] = 0;
        m_res[i] = 0; m_c[i] = 0; m_v[i] = 0; m_s[i] = 0; m_z[i] = 0; m_cnt[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        w  = (i == 0) ? 16 : 8;
        im = (i == 0) ? 7 : 3;
        vm = (longint'(1) << w) - 1;
        case (m_cnt[i])
          0: if (op_valid[i]) begin
               q_f[i] = op_fsel[i]; q_a[i] = int'(op_src_a[i]) & im; q_b[i] = int'(op_src_b[i]) & im;
               q_dst[i] = int'(op_dst[i]) & im; q_ie[i] = op_imm_en[i];
               q_imm[i] = longint'(op_imm[i]) & vm; m_cnt[i] = 1;
             end
          1: m_cnt[i] = 2;
          2: begin
               a = m_regs[i][q_a[i]];
               b = q_ie[i] ? q_imm[i] : m_regs[i][q_b[i]];
               alu_model(w, q_f[i], a, b, r, c, v);
               m_regs[i][q_dst[i]] = r;
               m_res[i] = r; m_c[i] = c; m_v[i] = v;
               m_s[i] = ((r >> (w - 1)) & 1) != 0;
               m_z[i] = (r == 0);
               m_cnt[i] = 3;
             end
          default: m_cnt[i] = 0;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      check_output("op_ready", i, longint'(rdy_o[i]), longint'(m_cnt[i] == 0));
      check_output("done", i, longint'(done_o[i]), longint'(m_cnt[i] == 3));
      check_output("result", i, longint'(res_o[i]), m_res[i]);
      check_output("flags_cvsz", i, longint'(flg_o[i]), longint'({m_c[i], m_v[i], m_s[i], m_z[i]}));
      check_output("dbg_data", i, longint'(dbg_o[i]), m_regs[i][int'(dbg_sel[i]) & ((i == 0) ? 7 : 3)]);
    end
  end

  task automatic apply_stimulus(input int t, input logic [2:0] f, input logic [2:0] sa,
                                input logic [2:0] sb, input logic ie, input logic [15:0] imm,
                                input logic [2:0] dst);
    int k, lat;
    k = 0;
    @(negedge clk);
    while (!rdy_o[t] && k < 20) begin @(negedge clk); k++; end
    check_output("ready_wait", t, longint'(k < 20), 1);
    op_fsel[t] = f; op_src_a[t] = sa; op_src_b[t] = sb;
    op_imm_en[t] = ie; op_imm[t] = imm; op_dst[t] = dst; op_valid[t] = 1'b1;
    @(negedge clk);
    op_valid[t] = 1'b0; op_dst[t] = ~dst; op_imm[t] = ~imm; op_src_a[t] = ~sa; op_src_b[t] = ~sb;
    lat = 1;
    while (!done_o[t] && lat < 10) begin @(negedge clk); lat++; end
    check_output("latency", t, lat, 3);
  endtask

  task automatic check_reg(input int t, input logic [2:0] idx, input longint exp);
    dbg_sel[t] = idx;
    #1;
    check_output("dbg_reg", t, longint'(dbg_o[t]), exp);
  endtask

  task automatic check_flags(input int t, input longint res, input logic [3:0] cvsz);
    check_output("lit_result", t, longint'(res_o[t]), res);
    check_output("lit_cvsz", t, longint'(flg_o[t]), longint'(cvsz));
  endtask

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin : stim
    int acc[$];
    int k;
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      op_valid[i] = 0; op_fsel[i] = 0; op_src_a[i] = 0; op_src_b[i] = 0;
      op_imm_en[i] = 0; op_imm[i] = 0; op_dst[i] = 0; dbg_sel[i] = 0;
    end
    repeat (2) @(negedge clk);
    check_output("rst_ready", 0, longint'(w_ready), 1);
    check_output("rst_done", 0, longint'(w_done), 0);
    check_flags(0, 0, 4'b0000);
    rst = 1'b1;

    // Abort an ADD into r5 while it is executing.
    apply_stimulus(0, 3'd6, 3'd0, 3'd0, 1'b1, 16'h1234, 3'd5);
    check_reg(0, 3'd5, 64'h1234);
    @(negedge clk);
    op_fsel[0] = 3'd0; op_src_a[0] = 3'd5; op_src_b[0] = 3'd5; op_imm_en[0] = 0; op_dst[0] = 3'd5;
    op_valid[0] = 1'b1;
    @(posedge clk);
    #1 op_valid[0] = 1'b0;
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check_output("abort_r5", 0, longint'(w_dbg), 0);
    check_flags(0, 0, 4'b0000);
    check_output("abort_ready", 0, longint'(w_ready), 1);
    @(posedge clk);
    #1 check_output("abort_hold_done", 0, longint'(w_done), 0);
    check_output("abort_hold_ready", 0, longint'(w_ready), 1);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_output("abort_no_done", 0, longint'(w_done), 0);
    end
    check_reg(0, 3'd5, 0);

    // Signed overflow on add.
    apply_stimulus(0, 3'd6, 3'd0, 3'd0, 1'b1, 16'h7FFF, 3'd1);
    apply_stimulus(0, 3'd6, 3'd0, 3'd0, 1'b1, 16'h0001, 3'd2);
    apply_stimulus(0, 3'd0, 3'd1, 3'd2, 1'b0, 16'h0000, 3'd3);
    check_flags(0, 64'h8000, 4'b0110);
    check_reg(0, 3'd3, 64'h8000);

    apply_stimulus(0, 3'd1, 3'd2, 3'd2, 1'b0, 16'h0000, 3'd4);
    check_flags(0, 0, 4'b1001);
    check_reg(0, 3'd4, 0);
    apply_stimulus(0, 3'd1, 3'd2, 3'd1, 1'b0, 16'h0000, 3'd2);
    check_flags(0, 64'h8002, 4'b0010);
    check_reg(0, 3'd2, 64'h8002);

    apply_stimulus(0, 3'd6, 3'd0, 3'd0, 1'b1, 16'hFFFF, 3'd6);
    apply_stimulus(0, 3'd7, 3'd6, 3'd0, 1'b0, 16'h0000, 3'd6);
    check_flags(0, 0, 4'b1001);
    check_reg(0, 3'd6, 0);
    apply_stimulus(0, 3'd2, 3'd6, 3'd1, 1'b0, 16'h0000, 3'd7);
    check_flags(0, 0, 4'b0001);
    check_reg(0, 3'd7, 0);

    // Held request with fields changing every cycle: only accept-edge values matter.
    for (k = 0; k < 12; k++) begin
      @(negedge clk);
      op_fsel[0] = 3'd6; op_imm_en[0] = 1'b1; op_imm[0] = 16'h0100 + 16'(k);
      op_dst[0] = 3'(k % 7); op_valid[0] = 1'b1;
      if (rdy_o[0]) acc.push_back(k);
    end
    @(negedge clk);
    op_valid[0] = 1'b0;
    check_output("hs_accepts", 0, acc.size(), 3);
    if (acc.size() == 3) begin
      check_output("hs_gap1", 0, acc[1] - acc[0], 4);
      check_output("hs_gap2", 0, acc[2] - acc[1], 4);
    end
    repeat (2) @(negedge clk);
    check_reg(0, 3'd0, 64'h0100);
    check_reg(0, 3'd4, 64'h0104);
    check_reg(0, 3'd1, 64'h0108);
    check_reg(0, 3'd2, 64'h8002);
    check_reg(0, 3'd3, 64'h8000);

    // Narrow instance: 8-bit carry-out wrap and full register bank.
    apply_stimulus(1, 3'd6, 3'd0, 3'd0, 1'b1, 16'h00FF, 3'd1);
    apply_stimulus(1, 3'd6, 3'd0, 3'd0, 1'b1, 16'h0001, 3'd2);
    apply_stimulus(1, 3'd0, 3'd1, 3'd2, 1'b0, 16'h0000, 3'd3);
    check_flags(1, 0, 4'b1001);
    check_reg(1, 3'd3, 0);
    apply_stimulus(1, 3'd6, 3'd0, 3'd0, 1'b1, 16'h00A0, 3'd0);
    apply_stimulus(1, 3'd6, 3'd0, 3'd0, 1'b1, 16'h00B1, 3'd1);
    apply_stimulus(1, 3'd6, 3'd0, 3'd0, 1'b1, 16'h00C2, 3'd2);
    apply_stimulus(1, 3'd6, 3'd0, 3'd0, 1'b1, 16'h00D3, 3'd3);
    check_reg(1, 3'd0, 64'hA0);
    check_reg(1, 3'd1, 64'hB1);
    check_reg(1, 3'd2, 64'hC2);
    check_reg(1, 3'd3, 64'hD3);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
